ram_param: RTL

Parametrised random-access memory for the Hack memory hierarchy. It generalises the fixed 16-bit × 512-word RAM to any word width and power-of-two depth. Reads are combinational and writes are synchronous. An optional hardware clear sweep zeroes every word after reset. It sits under the data-memory map and is the base block for RAM4K/RAM16K-class instances.

---
 rtl/hack_mem_pkg.sv | 18 +
 rtl/ram_clear_ctrl.sv | 48 ++++
 rtl/ram_param.sv | 65 ++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory hierarchy: word width, clear-FSM
// state encoding and the address widths of the standard RAM sizes.
package hack_mem_pkg;

  localparam int HACK_WORD_W = 16;

  typedef enum logic {
    RAM_STATE_IDLE  = 1'b0,
    RAM_STATE_CLEAR = 1'b1
  } ram_state_e;

  localparam int RAM8_ADDR_W   = 3;
  localparam int RAM64_ADDR_W  = 6;
  localparam int RAM512_ADDR_W = 9;
  localparam int RAM4K_ADDR_W  = 12;
  localparam int RAM16K_ADDR_W = 14;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sweep controller: walks ptr over every word once, then idles.
// Only present when RAM_PARAM_CLEAR_EN is defined.
`ifdef RAM_PARAM_CLEAR_EN
module ram_clear_ctrl
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W = RAM512_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic [ADDR_W-1:0] ptr,
  output logic              clr_we
);

  ram_state_e        state_q, state_n;
  logic [ADDR_W-1:0] ptr_q, ptr_n;

  always_ff @(posedge clk) begin
    state_q <= state_n;
    ptr_q   <= ptr_n;
  end

  // A reset edge restarts the sweep without writing; ptr wraps to 0 on the last word.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    clr_we  = 1'b0;
    if (reset) begin
      state_n = RAM_STATE_CLEAR;
      ptr_n   = '0;
    end else begin
      case (state_q)
        RAM_STATE_CLEAR: begin
          clr_we = 1'b1;
          ptr_n  = ptr_q + 1'b1;
          if (ptr_q == '1) state_n = RAM_STATE_IDLE;
        end
        default: state_n = RAM_STATE_IDLE;
      endcase
    end
  end

  assign busy = (state_q == RAM_STATE_CLEAR);
  assign ptr  = ptr_q;

endmodule
`endif

// File: rtl/ram_param.sv
// Parametrised RAM: combinational read, synchronous write. Defining
// RAM_PARAM_CLEAR_EN adds a post-reset sweep that zeroes every word.
module ram_param
  import hack_mem_pkg::*;
#(
  parameter int WIDTH  = HACK_WORD_W,
  parameter int ADDR_W = RAM512_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_en;

`ifdef RAM_PARAM_CLEAR_EN
  logic [ADDR_W-1:0] ptr;
  logic              clr_we;

  ram_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear (
    .clk    (clk),
    .reset  (reset),
    .busy   (busy),
    .ptr    (ptr),
    .clr_we (clr_we)
  );

  // The sweep owns the write port while busy; user writes never land during reset.
  always_comb begin
    wr_addr = addr;
    wr_data = in;
    wr_en   = load & ~reset;
    if (busy) begin
      wr_addr = ptr;
      wr_data = '0;
      wr_en   = clr_we;
    end
  end

  assign out = busy ? '0 : mem[addr];
`else
  logic unused_reset;

  assign unused_reset = reset;
  assign busy         = 1'b0;
  assign wr_addr      = addr;
  assign wr_data      = in;
  assign wr_en        = load;
  assign out          = mem[addr];
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule
